// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults, FSM encoding and signed max for the CNN pipeline.
package cnn_pkg;
    localparam int CNN_CH_NUM     = 18;
    localparam int CNN_DATA_WIDTH = 8;
    localparam int CNN_MAX_COLS   = 416;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    function automatic logic [CNN_DATA_WIDTH-1:0] smax(
        input logic [CNN_DATA_WIDTH-1:0] a,
        input logic [CNN_DATA_WIDTH-1:0] b
    );
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer: simple dual-port RAM holding one row of horizontal maxima.
module pool_line_buffer #(
    parameter int DEPTH = 208,
    parameter int WIDTH = 144,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_data
);
    logic [WIDTH-1:0] r_mem [DEPTH];

    // Array carries no reset so it can be inferred as block RAM.
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_rd_data <= '0;
        else if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
    end
endmodule

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: per-channel signed 2x2 stride-2 max-pool over a raster pixel stream.
module max_pool_2x2
    import cnn_pkg::*;
#(
    parameter int CH_NUM     = CNN_CH_NUM,
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int MAX_COLS   = CNN_MAX_COLS,
    parameter int DIM_WIDTH  = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DIM_WIDTH-1:0]         cfg_cols,
    input  logic [DIM_WIDTH-1:0]         cfg_rows,
    input  logic [CH_NUM*DATA_WIDTH-1:0] in_data,
    input  logic                         in_valid,
    output logic [CH_NUM*DATA_WIDTH-1:0] out_data,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         cfg_err
);
    localparam int W  = CH_NUM*DATA_WIDTH;
    localparam int AW = $clog2(MAX_COLS/2);

    state_t               r_state;
    logic [DIM_WIDTH-1:0] r_cols, r_rows, r_col, r_row;
    logic [W-1:0]         r_left;
    logic [W-1:0]         w_hmax, w_pool, w_rd_data;
    logic [AW-1:0]        w_addr;
    logic                 w_beat, w_last_col, w_last, w_cfg_ok;

    assign w_beat     = in_valid && r_state == RUN;
    assign w_last_col = r_col == r_cols - DIM_WIDTH'(1);
    assign w_last     = w_last_col && r_row == r_rows - DIM_WIDTH'(1);
    assign w_cfg_ok   = cfg_cols >= DIM_WIDTH'(2) && cfg_cols <= DIM_WIDTH'(MAX_COLS) &&
                        cfg_rows >= DIM_WIDTH'(2);
    assign w_addr     = AW'(r_col >> 1);
    assign busy       = r_state == RUN;

    for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
        assign w_hmax[k*DATA_WIDTH +: DATA_WIDTH] =
            smax(r_left[k*DATA_WIDTH +: DATA_WIDTH], in_data[k*DATA_WIDTH +: DATA_WIDTH]);
        assign w_pool[k*DATA_WIDTH +: DATA_WIDTH] =
            smax(w_rd_data[k*DATA_WIDTH +: DATA_WIDTH], w_hmax[k*DATA_WIDTH +: DATA_WIDTH]);
    end

    // Even rows store horizontal maxima; odd rows prefetch them on the even-column beat.
    pool_line_buffer #(.DEPTH(MAX_COLS/2), .WIDTH(W), .AW(AW)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_beat && r_col[0] && !r_row[0]),
        .i_wr_addr (w_addr),
        .i_wr_data (w_hmax),
        .i_rd_en   (w_beat && !r_col[0] && r_row[0]),
        .i_rd_addr (w_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cols     <= '0;
            r_rows     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_left     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            if (r_state == IDLE) begin
                if (start && w_cfg_ok) begin
                    r_state <= RUN;
                    r_cols  <= cfg_cols;
                    r_rows  <= cfg_rows;
                    r_col   <= '0;
                    r_row   <= '0;
                end else if (start) begin
                    cfg_err <= 1'b1;
                end
            end else if (in_valid) begin
                r_col <= w_last_col ? '0 : r_col + DIM_WIDTH'(1);
                if (w_last_col) r_row <= r_row + DIM_WIDTH'(1);
                if (!r_col[0]) r_left <= in_data;
                else if (r_row[0]) begin
                    out_data  <= w_pool;
                    out_valid <= 1'b1;
                end
                if (w_last) begin
                    r_state    <= IDLE;
                    frame_done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: directed self-checking bench for the 2x2 max-pool stage.
module tb_max_pool_2x2;
    import cnn_pkg::*;
    localparam int W = CNN_CH_NUM*CNN_DATA_WIDTH;

    logic         clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [9:0]   cfg_cols = '0, cfg_rows = '0;
    logic [W-1:0] in_data = '0;
    logic [W-1:0] out_data;
    logic         out_valid, busy, frame_done, cfg_err;
    int           n_checks = 0, n_pass = 0, n_fail = 0, n_done = 0, d0;
    logic [W-1:0] q[$], exp_q[$];
    logic [W-1:0] img[4][5];

    always #5 clk = ~clk;

    max_pool_2x2 dut (
        .clk(clk), .rst(rst), .start(start), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
        .in_data(in_data), .in_valid(in_valid), .out_data(out_data), .out_valid(out_valid),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
    );

    always @(negedge clk) begin
        if (out_valid) q.push_back(out_data);
        if (frame_done) n_done++;
    end

    initial begin
        #500000;
        $error("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    function automatic logic [W-1:0] ch(input int k, input logic [7:0] v);
        return W'(v) << (k*8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, " count"}, W'(q.size()), W'(exp_q.size()));
        foreach (exp_q[i])
            chk($sformatf("%s out%0d", tag, i), (i < q.size()) ? q[i] : {W{1'bx}}, exp_q[i]);
        q.delete();
        exp_q.delete();
    endtask

    task automatic do_start(input int c, input int r);
        cfg_cols = 10'(c);
        cfg_rows = 10'(r);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic beat(input int r, input int c);
        in_data  = img[r][c];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input int cols, input int rows, input bit gapped);
        int g;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                beat(r, c);
                if (gapped && !(r == rows-1 && c == cols-1)) begin
                    g = ((r*cols + c) % 2 == 0) ? 1 : 0;
                    if ($urandom_range(0, 3) == 0) g = 3;
                    repeat (g) tick();
                end
            end
    endtask

    task automatic clear_img();
        foreach (img[i, j]) img[i][j] = '0;
    endtask

    task automatic ramp_img();
        clear_img();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = ch(0, 8'(r*4 + c));
    endtask

    initial begin
        tick();
        chk("reset out_valid", W'(out_valid), '0);
        chk("reset out_data", out_data, '0);
        chk("reset busy", W'(busy), '0);
        chk("reset frame_done", W'(frame_done), '0);
        chk("reset cfg_err", W'(cfg_err), '0);
        rst = 1'b0;
        tick();

        // Beats while IDLE must be dropped.
        in_data  = {CNN_CH_NUM{8'h7F}};
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        chk("idle beats dropped", W'(q.size()), '0);

        // Basic 4x4 ramp
        ramp_img();
        do_start(4, 4);
        chk("basic busy", W'(busy), W'(1));
        send_frame(4, 4, 1'b0);
        chk("basic frame_done", W'(frame_done), W'(1));
        chk("basic last out_valid", W'(out_valid), W'(1));
        chk("basic last out_data", out_data, ch(0, 8'd15));
        tick();
        chk("basic busy after", W'(busy), '0);
        chk("basic out_data held", out_data, ch(0, 8'd15));
        exp_q = '{ch(0, 8'd5), ch(0, 8'd7), ch(0, 8'd13), ch(0, 8'd15)};
        chk_outs("basic");

        // Signed compare on all channels
        img[0][0] = {CNN_CH_NUM{8'h80}};
        img[0][1] = {CNN_CH_NUM{8'hFF}};
        img[1][0] = {CNN_CH_NUM{8'hF9}};
        img[1][1] = {CNN_CH_NUM{8'h9C}};
        do_start(2, 2);
        send_frame(2, 2, 1'b0);
        chk("signed frame_done", W'(frame_done), W'(1));
        tick();
        exp_q = '{{CNN_CH_NUM{8'hFF}}};
        chk_outs("signed");

        // Odd dimensions 5x3: trailing column and row discarded
        clear_img();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 5; c++) img[r][c] = ch(0, 8'(r*5 + c));
        do_start(5, 3);
        send_frame(5, 3, 1'b0);
        chk("odd frame_done", W'(frame_done), W'(1));
        chk("odd no out_valid at done", W'(out_valid), '0);
        tick();
        chk("odd frame_done pulse", W'(frame_done), '0);
        exp_q = '{ch(0, 8'd6), ch(0, 8'd8)};
        chk_outs("odd");

        // Gapped 4x4 must match the continuous run
        ramp_img();
        do_start(4, 4);
        send_frame(4, 4, 1'b1);
        chk("gapped frame_done", W'(frame_done), W'(1));
        tick();
        exp_q = '{ch(0, 8'd5), ch(0, 8'd7), ch(0, 8'd13), ch(0, 8'd15)};
        chk_outs("gapped");

        // Illegal configurations
        do_start(1, 4);
        chk("cols=1 cfg_err", W'(cfg_err), W'(1));
        chk("cols=1 busy", W'(busy), '0);
        tick();
        chk("cfg_err pulse", W'(cfg_err), '0);
        do_start(417, 2);
        chk("cols=417 cfg_err", W'(cfg_err), W'(1));
        do_start(4, 1);
        chk("rows=1 cfg_err", W'(cfg_err), W'(1));
        chk("rows=1 busy", W'(busy), '0);

        // Back-to-back frames with starts ignored during RUN
        clear_img();
        img[0][0] = ch(17, 8'd3);
        img[0][1] = ch(17, 8'hFB);
        img[1][0] = ch(17, 8'd10);
        img[1][1] = ch(17, 8'd2);
        do_start(2, 2);
        send_frame(2, 2, 1'b0);
        chk("b2b A frame_done", W'(frame_done), W'(1));
        chk("b2b A out_data", out_data, ch(17, 8'h0A));
        clear_img();
        img[0][0] = ch(5, 8'd9);  img[0][1] = ch(5, 8'd2);
        img[0][2] = ch(5, 8'hFD); img[0][3] = ch(5, 8'd4);
        img[1][0] = ch(5, 8'd5);  img[1][1] = ch(5, 8'd6);
        img[1][2] = ch(5, 8'hF9); img[1][3] = ch(5, 8'hF8);
        do_start(4, 2);
        chk("b2b B accepted", W'(busy), W'(1));
        beat(0, 0);
        beat(0, 1);
        beat(0, 2);
        do_start(1, 1);
        chk("run start no cfg_err", W'(cfg_err), '0);
        chk("run start busy", W'(busy), W'(1));
        do_start(2, 2);
        chk("run legal start busy", W'(busy), W'(1));
        beat(0, 3);
        for (int c = 0; c < 4; c++) beat(1, c);
        chk("b2b B frame_done", W'(frame_done), W'(1));
        chk("b2b B out_data", out_data, ch(5, 8'd4));
        tick();
        exp_q = '{ch(17, 8'h0A), ch(5, 8'd9), ch(5, 8'd4)};
        chk_outs("b2b");

        // Reset mid-frame, then a fresh frame
        ramp_img();
        do_start(4, 4);
        for (int i = 0; i < 9; i++) beat(i / 4, i % 4);
        rst = 1'b1;
        #1;
        chk("midrst busy", W'(busy), '0);
        chk("midrst out_data", out_data, '0);
        tick();
        rst = 1'b0;
        q.delete();
        d0 = n_done;
        repeat (3) tick();
        chk("midrst no spurious", W'(q.size()), '0);
        clear_img();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) img[r][c] = ch(3, 8'(15 - (r*4 + c)));
        do_start(4, 4);
        send_frame(4, 4, 1'b0);
        tick();
        chk("midrst done count", W'(n_done - d0), W'(1));
        exp_q = '{ch(3, 8'd15), ch(3, 8'd13), ch(3, 8'd7), ch(3, 8'd5)};
        chk_outs("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/max_pool_2x2.md
# max_pool_2x2

Downstream stage of the convolution unit. Consumes the 18-channel, 8-bit-per-channel `MAC_data_out`/`MAC_data_valid_out` pixel stream in raster order. Performs a signed 2×2 stride-2 max-pool per channel and emits one pooled pixel per 2×2 window toward the output packer. One row of horizontal maxima is held in an internal line buffer.

## Interface
Parameters:
- `CH_NUM`, 18: channels per pixel beat.
- `DATA_WIDTH`, 8: signed bits per channel.
- `MAX_COLS`, 416: maximum input frame width. Must be even.
- `DIM_WIDTH`, 10: width of the `cfg_cols`/`cfg_rows` fields.

Ports:
- `clk`, in, 1: single clock. All logic is rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse. Latches the cfg fields and begins a frame.
- `cfg_cols`, in, DIM_WIDTH: input frame width in pixels.
- `cfg_rows`, in, DIM_WIDTH: input frame height in pixels.
- `in_data`, in, CH_NUM*DATA_WIDTH: pixel beat. Channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `in_valid`, in, 1: beat qualifier. There is no backpressure.
- `out_data`, out, CH_NUM*DATA_WIDTH: pooled pixel, using the same packing as `in_data`.
- `out_valid`, out, 1: pooled-pixel qualifier.
- `busy`, out, 1: high while state is RUN.
- `frame_done`, out, 1: one-cycle pulse at the end of a frame.
- `cfg_err`, out, 1: one-cycle pulse when a `start` carries illegal dimensions.

## Operation
- States are IDLE and RUN.
  - IDLE→RUN on `start` with 2 ≤ `cfg_cols` ≤ MAX_COLS and `cfg_rows` ≥ 2. The cfg fields are latched, `col` and `row` are cleared, and `busy` goes high on the next cycle.
  - A `start` with illegal dimensions keeps the block in IDLE and pulses `cfg_err` on the next cycle.
  - `start` is ignored while in RUN.
- In IDLE, `in_valid` beats are dropped.
- In RUN, each `in_valid` beat advances `col`. At `col == cols-1`, `col` wraps to 0 and `row` increments.
- Even column: the beat is stored in the `left` register.
- Odd column: `hmax[k] = smax(left[k], in[k])` for every k.
  - Even row: `hmax` is written to the line buffer at address `col>>1`.
  - Odd row: the line buffer is read at `col>>1`, and `out[k] = smax(buf[k], hmax[k])`.
- Odd frame dimensions: the trailing column and/or row are consumed but discarded (floor pooling). Output is floor(cols/2) × floor(rows/2) pixels in raster order.
- The last input beat is the one at `row == rows-1` and `col == cols-1`. On that beat the state returns to IDLE and `frame_done` pulses on the next cycle.
- All comparisons are signed two's complement, DATA_WIDTH wide, with no saturation or rescale. On ties, either operand is acceptable since the values are equal.
- Line-buffer contents are never cleared. Every read address is written in the preceding even row before it is read.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, `frame_done`=0, `cfg_err`=0, state=IDLE, counters=0.
- Line-buffer read is synchronous. The read address is issued on the odd row's even-column beat, and the data is used on the following odd-column beat, even if `in_valid` gaps separate the two beats.
- Latency: `out_valid` rises 1 cycle after the odd-row, odd-column input beat. `out_data` is registered and holds until the next `out_valid`.
- `frame_done` follows 1 cycle after the last input beat.
  - It coincides with the final `out_valid` when both dimensions are even.
  - Otherwise it stands alone, with no `out_valid` beat.
- Maximum throughput is one input beat per cycle with no bubbles required. Back-to-back frames are allowed: `start` is accepted in the cycle the block returns to IDLE.
- Asserting `rst` mid-frame drops the frame with no `out_valid` or `frame_done` pulse. `rst` has immediate asynchronous effect on every register except the line-buffer array.

## Structure
- Shared package `cnn_pkg`: CH_NUM, DATA_WIDTH, and MAX_COLS defaults; the state encoding (IDLE=0, RUN=1); and the `smax` signed-max function.
- Sub-module `pool_line_buffer`: simple dual-port, depth MAX_COLS/2, width CH_NUM*DATA_WIDTH, with synchronous write and registered synchronous read. It must map to block RAM.
- The top of the block holds the FSM, the column/row counters, the `left` register, the per-channel max tree, and the output register.

## Test plan
- **Basic 4×4 frame**: one channel set to (r*4+c), others 0, continuous valid. Expect 4 outputs of 5, 7, 13, 15. `frame_done` coincides with the 4th `out_valid`.
- **Signed compare**: a 2×2 window of −128, −1, −7, −100 on all channels. Expect every channel = −1 (0xFF).
- **Odd dimensions**: 5×3 frame. Expect exactly 2 outputs, taken from rows 0–1, columns 0–3. `frame_done` arrives 1 cycle after beat 15 with no coincident `out_valid`.
- **Gapped input**: 4×4 frame with `in_valid` toggling 1/0 and random 3-cycle gaps. Outputs must match the continuous-valid run.
- **Back-to-back frames and config errors**: a second `start` in the IDLE-return cycle is accepted. A `start` with `cfg_cols`=1 gives `cfg_err` and no `busy`. A `start` during RUN is ignored.
- **Reset mid-frame**: assert `rst` at beat 9 of a 4×4 frame, then start a new frame. Expect no spurious output, and the correct 4 outputs from the new frame.
